// File: rtl/ram_pkg.sv
// ram_pkg: shared constants and helpers for the parametrised RAM controller.
//   - FSM state encodings (INIT sweep, IDLE, READ_WAIT for two-cycle reads)
//   - byte-enable width for the default 32-bit word
//   - constant functions for byte-enable width and sweep-pointer width
package ram_pkg;

  localparam logic [1:0] ST_INIT      = 2'd0;
  localparam logic [1:0] ST_IDLE      = 2'd1;
  localparam logic [1:0] ST_READ_WAIT = 2'd2;

  localparam int DEF_DATA_WIDTH = 32'sd32;
  localparam int BE_WIDTH       = DEF_DATA_WIDTH / 32'sd8;

  // Number of byte lanes in a word of the given width.
  function automatic int be_width(input int data_width);
    return data_width / 32'sd8;
  endfunction

  // clog2(depth), never less than one bit so a single-word RAM still has a pointer.
  function automatic int ptr_width(input int depth);
    int w;
    int v;
    w = 32'sd0;
    v = 32'sd1;
    while (v < depth) begin
      v = v * 32'sd2;
      w = w + 32'sd1;
    end
    if (w < 32'sd1) begin
      w = 32'sd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/ram_array.sv
// ram_array: plain synchronous byte-write storage with a registered read port.
// No reset, so the storage maps onto block RAM.
//   clock  rising-edge clock
//   we     write enable (byte lanes qualified by be)
//   re     read enable; rdata updates only on an enabled read
//   be     byte enables, bit i covers wdata[8i+7:8i]
//   addr   word index (caller guarantees addr < DEPTH when writing)
//   wdata  write data
//   rdata  registered read data, holds between reads
module ram_array
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 512
) (
  input  logic                          clock,
  input  logic                          we,
  input  logic                          re,
  input  logic [DATA_WIDTH/8-1:0]       be,
  input  logic [ptr_width(DEPTH)-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  output logic [DATA_WIDTH-1:0]         rdata
);

  localparam int BW = be_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_r;

  // Byte-lane writes and registered read of the storage array.
  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < BW; i++) begin
        if (be[i]) begin
          mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    if (re) begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/ram_ctrl.sv
// ram_ctrl: handshaked RAM controller with zero-fill sweep after reset.
//   clock     rising-edge clock
//   clear     asynchronous active-high reset; restarts the INIT sweep
//   req       request strobe, sampled only while busy=0
//   we        1=write, 0=read
//   be        per-byte write enables
//   address   word address; address >= DEPTH flags err and touches nothing
//   data_in   write data
//   data_out  read data, holds until the next completed read
//   ack       one-cycle completion pulse per accepted request
//   err       pulses with ack for an out-of-range address
//   busy      high during INIT and READ_WAIT
module ram_ctrl
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 9,
  parameter int DEPTH        = 512,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic                    req,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    ack,
  output logic                    err,
  output logic                    busy
);

  localparam int                  BW       = be_width(DATA_WIDTH);
  localparam int                  PW       = ptr_width(DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_V  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [PW-1:0]       LAST_PTR = PW'(DEPTH - 1);

  logic [1:0]            state_r;
  logic [PW-1:0]         ptr_r;
  logic                  ack_r;
  logic                  err_r;
  logic                  rd_sel_r;    // one-cycle mode: last completed read was in range
  logic                  rd_oor_r;    // two-cycle mode: pending read is out of range
  logic [DATA_WIDTH-1:0] data_out_r;  // two-cycle mode output register

  logic                  in_range_s;
  logic                  arr_we_s;
  logic                  arr_re_s;
  logic [BW-1:0]         arr_be_s;
  logic [PW-1:0]         arr_addr_s;
  logic [DATA_WIDTH-1:0] arr_wdata_s;
  logic [DATA_WIDTH-1:0] arr_rdata_s;

  assign in_range_s = ({1'b0, address} < DEPTH_V);

  // Steer the array port between the zero-fill sweep and host requests.
  always_comb begin
    arr_we_s    = 1'b0;
    arr_re_s    = 1'b0;
    arr_be_s    = {BW{1'b0}};
    arr_addr_s  = address[PW-1:0];
    arr_wdata_s = data_in;
    case (state_r)
      ST_INIT: begin
        // Held off while clear is high so the sweep starts cleanly at word 0.
        arr_we_s    = ~clear;
        arr_be_s    = {BW{1'b1}};
        arr_addr_s  = ptr_r;
        arr_wdata_s = {DATA_WIDTH{1'b0}};
      end
      ST_IDLE: begin
        if (req && we) begin
          arr_we_s = in_range_s;  // out-of-range writes are dropped
          arr_be_s = be;
        end else if (req) begin
          arr_re_s = 1'b1;
        end else begin
          arr_we_s = 1'b0;
        end
      end
      default: begin
        arr_we_s = 1'b0;
      end
    endcase
  end

  // FSM, sweep pointer, handshake pulses and read-data staging.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_r    <= ST_INIT;
      ptr_r      <= {PW{1'b0}};
      ack_r      <= 1'b0;
      err_r      <= 1'b0;
      rd_sel_r   <= 1'b0;
      rd_oor_r   <= 1'b0;
      data_out_r <= {DATA_WIDTH{1'b0}};
    end else begin
      ack_r <= 1'b0;
      err_r <= 1'b0;
      case (state_r)
        ST_INIT: begin
          if (ptr_r == LAST_PTR) begin
            state_r <= ST_IDLE;
            ptr_r   <= {PW{1'b0}};
          end else begin
            ptr_r <= ptr_r + PW'(1'b1);
          end
        end
        ST_IDLE: begin
          if (req) begin
            if (we) begin
              ack_r <= 1'b1;
              err_r <= ~in_range_s;
            end else if (READ_LATENCY == 32'sd1) begin
              ack_r    <= 1'b1;
              err_r    <= ~in_range_s;
              rd_sel_r <= in_range_s;
            end else begin
              state_r  <= ST_READ_WAIT;
              rd_oor_r <= ~in_range_s;
            end
          end
        end
        ST_READ_WAIT: begin
          state_r    <= ST_IDLE;
          ack_r      <= 1'b1;
          err_r      <= rd_oor_r;
          data_out_r <= rd_oor_r ? {DATA_WIDTH{1'b0}} : arr_rdata_s;
        end
        default: begin
          state_r <= ST_INIT;
          ptr_r   <= {PW{1'b0}};
        end
      endcase
    end
  end

  // In one-cycle mode the array read register is the data register; rd_sel_r
  // forces zero after reset and for out-of-range reads.
  assign data_out = (READ_LATENCY == 32'sd1) ?
                    (rd_sel_r ? arr_rdata_s : {DATA_WIDTH{1'b0}}) : data_out_r;
  assign ack      = ack_r;
  assign err      = err_r;
  assign busy     = (state_r != ST_IDLE);

  ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clock (clock),
    .we    (arr_we_s),
    .re    (arr_re_s),
    .be    (arr_be_s),
    .addr  (arr_addr_s),
    .wdata (arr_wdata_s),
    .rdata (arr_rdata_s)
  );

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: directed self-checking bench.
//   dut0: 512 words, one-cycle reads.  dut1: 300 words, two-cycle reads.
module tb_ram_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        clr  [2];
  logic        rq   [2];
  logic        wr   [2];
  logic [3:0]  bes  [2];
  logic [8:0]  adr  [2];
  logic [31:0] din  [2];
  logic [31:0] dout [2];
  logic        ack  [2];
  logic        err  [2];
  logic        busy [2];

  int n_checks = 0;
  int n_fail   = 0;

  ram_ctrl dut0 (
    .clock(clock), .clear(clr[0]), .req(rq[0]), .we(wr[0]), .be(bes[0]),
    .address(adr[0]), .data_in(din[0]), .data_out(dout[0]), .ack(ack[0]),
    .err(err[0]), .busy(busy[0])
  );

  ram_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .DEPTH(300), .READ_LATENCY(2)) dut1 (
    .clock(clock), .clear(clr[1]), .req(rq[1]), .we(wr[1]), .be(bes[1]),
    .address(adr[1]), .data_in(din[1]), .data_out(dout[1]), .ack(ack[1]),
    .err(err[1]), .busy(busy[1])
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [3:0] b,
                         input logic [8:0] a, input logic [31:0] d);
    rq[i] = 1'b1; wr[i] = w; bes[i] = b; adr[i] = a; din[i] = d;
  endtask

  task automatic idle_in(input int i);
    rq[i] = 1'b0; wr[i] = 1'b0; bes[i] = 4'h0;
  endtask

  // Ticks until busy drops or the budget runs out, counting acks seen meanwhile.
  task automatic wait_idle(input int i, input int budget, output int cycles,
                           output bit timed_out, output int acks);
    cycles = 0; acks = 0; timed_out = 1'b0;
    while (busy[i] === 1'b1 || busy[i] === 1'bx) begin
      if (cycles >= budget) begin
        timed_out = 1'b1;
        break;
      end
      tick();
      cycles++;
      if (ack[i] === 1'b1) acks++;
    end
  endtask

  task automatic test_reset();
    int cyc; bit to; int acks;
    int exp_cyc [2];
    exp_cyc[0] = 512; exp_cyc[1] = 300;
    for (int i = 0; i < 2; i++) begin
      clr[i] = 1'b1; idle_in(i); adr[i] = 9'd0; din[i] = 32'h0;
    end
    #3;
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (dout[i] !== 32'h0) begin n_fail++; $display("FAIL reset_dout[%0d]: got %h want 00000000", i, dout[i]); end
      n_checks++; if (ack[i] !== 1'b0) begin n_fail++; $display("FAIL reset_ack[%0d]: got %b want 0", i, ack[i]); end
      n_checks++; if (err[i] !== 1'b0) begin n_fail++; $display("FAIL reset_err[%0d]: got %b want 0", i, err[i]); end
      n_checks++; if (busy[i] !== 1'b1) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b want 1", i, busy[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      clr[i] = 1'b0;
      if (i == 0) set_req(0, 1'b0, 4'hF, 9'd3, 32'h0);  // must be ignored during INIT
      wait_idle(i, 1000, cyc, to, acks);
      idle_in(i);
      n_checks++; if (to) begin n_fail++; $display("FAIL init_timeout[%0d]: busy still high after %0d cycles", i, cyc); end
      n_checks++; if (cyc !== exp_cyc[i]) begin n_fail++; $display("FAIL init_len[%0d]: got %0d want %0d", i, cyc, exp_cyc[i]); end
      n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL init_ack[%0d]: got %0d acks want 0", i, acks); end
    end
  endtask

  task automatic test_sweep_zero();
    int cyc; bit to; int acks;
    logic [8:0] a [3];
    a[0] = 9'd0; a[1] = 9'd255; a[2] = 9'd511;
    for (int k = 0; k < 3; k++) begin
      set_req(0, 1'b1, 4'hF, a[k], 32'hBAD0_0000 | 32'(a[k]));
      tick();
    end
    set_req(0, 1'b0, 4'h0, 9'd255, 32'h0);
    tick();
    idle_in(0);
    n_checks++; if (dout[0] !== 32'hBAD0_00FF) begin n_fail++; $display("FAIL garbage_rd: got %h want bad000ff", dout[0]); end
    clr[0] = 1'b1;
    #2;
    n_checks++; if (dout[0] !== 32'h0) begin n_fail++; $display("FAIL clear_dout: got %h want 00000000", dout[0]); end
    clr[0] = 1'b0;
    wait_idle(0, 1000, cyc, to, acks);
    n_checks++; if (cyc !== 512 || to) begin n_fail++; $display("FAIL resweep_len: got %0d want 512", cyc); end
    for (int k = 0; k < 3; k++) begin
      set_req(0, 1'b0, 4'h0, a[k], 32'h0);
      tick();
      idle_in(0);
      n_checks++; if (ack[0] !== 1'b1) begin n_fail++; $display("FAIL zero_ack[%0d]: got %b want 1", a[k], ack[0]); end
      n_checks++; if (dout[0] !== 32'h0) begin n_fail++; $display("FAIL zero_rd[%0d]: got %h want 00000000", a[k], dout[0]); end
      tick();
      n_checks++; if (ack[0] !== 1'b0) begin n_fail++; $display("FAIL ack_pulse[%0d]: got %b want 0", a[k], ack[0]); end
    end
  endtask

  task automatic test_byte_enables();
    set_req(0, 1'b1, 4'b1111, 9'd5, 32'hDEADBEEF); tick();
    n_checks++; if (ack[0] !== 1'b1 || err[0] !== 1'b0) begin n_fail++; $display("FAIL be_wr1_ack: got ack=%b err=%b want 1/0", ack[0], err[0]); end
    set_req(0, 1'b1, 4'b0101, 9'd5, 32'h11223344); tick();
    n_checks++; if (ack[0] !== 1'b1) begin n_fail++; $display("FAIL be_wr2_ack: got %b want 1", ack[0]); end
    set_req(0, 1'b0, 4'b0000, 9'd5, 32'h0); tick();
    n_checks++; if (dout[0] !== 32'hDE22BE44) begin n_fail++; $display("FAIL be_merge: got %h want de22be44", dout[0]); end
    set_req(0, 1'b1, 4'b0000, 9'd5, 32'hFFFFFFFF); tick();
    n_checks++; if (ack[0] !== 1'b1) begin n_fail++; $display("FAIL be_zero_ack: got %b want 1", ack[0]); end
    n_checks++; if (dout[0] !== 32'hDE22BE44) begin n_fail++; $display("FAIL wr_keeps_dout: got %h want de22be44", dout[0]); end
    set_req(0, 1'b0, 4'b0000, 9'd5, 32'h0); tick();
    idle_in(0);
    n_checks++; if (dout[0] !== 32'hDE22BE44) begin n_fail++; $display("FAIL be_zero_noop: got %h want de22be44", dout[0]); end
    tick();
    n_checks++; if (ack[0] !== 1'b0 || dout[0] !== 32'hDE22BE44) begin n_fail++; $display("FAIL be_hold: got ack=%b dout=%h want 0/de22be44", ack[0], dout[0]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    vals[0] = 32'h0000_1111; vals[1] = 32'hA0B1_C2D3; vals[2] = 32'h8765_4321;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) set_req(0, 1'b1, 4'hF, 9'(10 + k / 2), vals[k / 2]);
      else            set_req(0, 1'b0, 4'h0, 9'(10 + k / 2), 32'h0);
      tick();
      n_checks++; if (ack[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_ack[%0d]: got %b want 1", k, ack[0]); end
      if (k % 2 == 1) begin
        n_checks++; if (dout[0] !== vals[k / 2]) begin n_fail++; $display("FAIL b2b_raw[%0d]: got %h want %h", k, dout[0], vals[k / 2]); end
      end
    end
    idle_in(0);
    tick();
    n_checks++; if (ack[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b want 0", ack[0]); end
  endtask

  task automatic test_latency2();
    set_req(1, 1'b1, 4'hF, 9'd7, 32'h12345678); tick();
    n_checks++; if (ack[1] !== 1'b1 || busy[1] !== 1'b0) begin n_fail++; $display("FAIL l2_wr: got ack=%b busy=%b want 1/0", ack[1], busy[1]); end
    idle_in(1); tick();
    set_req(1, 1'b0, 4'h0, 9'd7, 32'h0); tick();           // edge N
    n_checks++; if (busy[1] !== 1'b1 || ack[1] !== 1'b0) begin n_fail++; $display("FAIL l2_wait: got busy=%b ack=%b want 1/0", busy[1], ack[1]); end
    adr[1] = 9'd0;                                          // req held while busy
    tick();                                                 // edge N+1
    n_checks++; if (ack[1] !== 1'b1 || busy[1] !== 1'b0) begin n_fail++; $display("FAIL l2_ack: got ack=%b busy=%b want 1/0", ack[1], busy[1]); end
    n_checks++; if (dout[1] !== 32'h12345678) begin n_fail++; $display("FAIL l2_data: got %h want 12345678", dout[1]); end
    tick();                                                 // edge N+2: held req accepted
    idle_in(1);
    n_checks++; if (busy[1] !== 1'b1 || ack[1] !== 1'b0) begin n_fail++; $display("FAIL l2_held: got busy=%b ack=%b want 1/0", busy[1], ack[1]); end
    tick();
    n_checks++; if (ack[1] !== 1'b1 || dout[1] !== 32'h0) begin n_fail++; $display("FAIL l2_held_data: got ack=%b dout=%h want 1/00000000", ack[1], dout[1]); end
    tick();
    n_checks++; if (ack[1] !== 1'b0) begin n_fail++; $display("FAIL l2_pulse: got %b want 0", ack[1]); end
  endtask

  task automatic test_out_of_range();
    logic [8:0]  ra [3];
    logic [31:0] rv [3];
    logic        re [3];
    ra[0] = 9'd299; rv[0] = 32'h0BADCAFE; re[0] = 1'b0;
    ra[1] = 9'd400; rv[1] = 32'h00000000; re[1] = 1'b1;
    ra[2] = 9'd299; rv[2] = 32'h0BADCAFE; re[2] = 1'b0;
    set_req(1, 1'b1, 4'hF, 9'd299, 32'h0BADCAFE); tick();
    n_checks++; if (ack[1] !== 1'b1 || err[1] !== 1'b0) begin n_fail++; $display("FAIL oor_wr299: got ack=%b err=%b want 1/0", ack[1], err[1]); end
    set_req(1, 1'b1, 4'hF, 9'd400, 32'hA5A5A5A5); tick();
    n_checks++; if (ack[1] !== 1'b1 || err[1] !== 1'b1) begin n_fail++; $display("FAIL oor_wr400: got ack=%b err=%b want 1/1", ack[1], err[1]); end
    idle_in(1); tick();
    n_checks++; if (ack[1] !== 1'b0 || err[1] !== 1'b0) begin n_fail++; $display("FAIL oor_pulse: got ack=%b err=%b want 0/0", ack[1], err[1]); end
    for (int k = 0; k < 3; k++) begin
      set_req(1, 1'b0, 4'h0, ra[k], 32'h0); tick();
      idle_in(1); tick();
      n_checks++; if (ack[1] !== 1'b1 || err[1] !== re[k]) begin n_fail++; $display("FAIL oor_rd_flags[%0d]: got ack=%b err=%b want 1/%b", k, ack[1], err[1], re[k]); end
      n_checks++; if (dout[1] !== rv[k]) begin n_fail++; $display("FAIL oor_rd_data[%0d]: got %h want %h", k, dout[1], rv[k]); end
    end
  endtask

  task automatic test_clear_mid_read();
    int cyc; bit to; int acks;
    set_req(1, 1'b0, 4'h0, 9'd299, 32'h0); tick();
    idle_in(1);
    n_checks++; if (busy[1] !== 1'b1) begin n_fail++; $display("FAIL cmr_wait: got busy=%b want 1", busy[1]); end
    clr[1] = 1'b1;
    #1;
    n_checks++; if (dout[1] !== 32'h0 || ack[1] !== 1'b0) begin n_fail++; $display("FAIL cmr_async: got dout=%h ack=%b want 00000000/0", dout[1], ack[1]); end
    tick();
    n_checks++; if (ack[1] !== 1'b0 || busy[1] !== 1'b1) begin n_fail++; $display("FAIL cmr_no_ack: got ack=%b busy=%b want 0/1", ack[1], busy[1]); end
    clr[1] = 1'b0;
    wait_idle(1, 1000, cyc, to, acks);
    n_checks++; if (cyc !== 300 || to) begin n_fail++; $display("FAIL cmr_resweep: got %0d want 300", cyc); end
    n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL cmr_sweep_ack: got %0d acks want 0", acks); end
    set_req(1, 1'b0, 4'h0, 9'd299, 32'h0); tick();
    idle_in(1); tick();
    n_checks++; if (ack[1] !== 1'b1 || dout[1] !== 32'h0) begin n_fail++; $display("FAIL cmr_zeroed: got ack=%b dout=%h want 1/00000000", ack[1], dout[1]); end
  endtask

  initial begin
    test_reset();
    test_sweep_zero();
    test_byte_enables();
    test_back_to_back();
    test_latency2();
    test_out_of_range();
    test_clear_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
